ps2_key_event_ctrl: RTL and testbench

//  Sequences raw PS/2 scan-code bytes from the ps2 byte receiver into key events.

---
 rtl/ps2_key_event_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ps2_key_event_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into key events, filters typematic repeats,
// and queues the events in a small FIFO behind a valid/ready interface.
module ps2_key_event_ctrl #(
    parameter int DEPTH           = 4,
    parameter int TIMEOUT_CYCLES  = 100000,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic                     clk_50mhz,
    input  logic                     reset,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    input  logic                     ev_ready,
    input  logic                     overflow_clr,
    output logic                     ev_valid,
    output logic [7:0]               ev_code,
    output logic                     ev_ext,
    output logic                     ev_break,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [7:0]               last_make
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK} state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    ev_t             mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q;
    logic [7:0]      held_code_q;
    logic            held_ext_q;
    logic            held_vld_q;
    logic [7:0]      last_make_q;

    logic            emit;
    ev_t             emit_ev;
    logic            is_noise;
    logic            timeout;
    logic            held_match;
    logic            push;
    logic            push_ok;
    logic            pop;
    logic            drop;
    ev_t             head;

    always_comb begin
        state_d  = state_q;
        emit     = 1'b0;
        emit_ev  = '{code: byte_in, ext: 1'b0, brk: 1'b0};
        is_noise = byte_in inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE};
        timeout  = !byte_valid && (state_q != S_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

        if (byte_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (byte_in == 8'hE0)      state_d = S_EXT;
                    else if (byte_in == 8'hF0) state_d = S_BRK;
                    else if (!is_noise)        emit = 1'b1;
                end
                S_EXT: begin
                    if (byte_in == 8'hF0) begin
                        state_d = S_EXTBRK;
                    end else if (byte_in != 8'hE0) begin
                        emit        = 1'b1;
                        emit_ev.ext = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (byte_in != 8'hE0 && byte_in != 8'hF0) begin
                        emit        = 1'b1;
                        emit_ev.brk = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                default: begin
                    if (byte_in != 8'hE0 && byte_in != 8'hF0) begin
                        emit        = 1'b1;
                        emit_ev.ext = 1'b1;
                        emit_ev.brk = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            endcase
        end else if (timeout) begin
            state_d = S_IDLE;
        end

        tmo_d = (byte_valid || state_q == S_IDLE || timeout) ? '0 : tmo_q + 1'b1;

        // Only makes are filtered; breaks always reach the consumer.
        held_match = held_vld_q && (held_code_q == emit_ev.code) && (held_ext_q == emit_ev.ext);
        push       = emit && !(!emit_ev.brk && SUPPRESS_REPEAT && held_match);

        pop     = ev_valid && ev_ready;
        push_ok = push && ((cnt_q != CW'(DEPTH)) || pop);
        drop    = push && !push_ok;

        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            held_code_q <= 8'h00;
            held_ext_q  <= 1'b0;
            held_vld_q  <= 1'b0;
            last_make_q <= 8'h00;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            if (push_ok) begin
                mem_q[wr_q] <= emit_ev;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;

            if (drop)              ovf_q <= 1'b1;
            else if (overflow_clr) ovf_q <= 1'b0;

            // Held-key tracking follows every accepted make, even one lost to a full FIFO.
            if (push && !emit_ev.brk) begin
                held_code_q <= emit_ev.code;
                held_ext_q  <= emit_ev.ext;
                held_vld_q  <= 1'b1;
                last_make_q <= emit_ev.code;
            end else if (push && emit_ev.brk && held_match) begin
                held_vld_q  <= 1'b0;
            end
        end
    end

    assign head       = mem_q[rd_q];
    assign ev_valid   = (cnt_q != '0);
    assign ev_code    = ev_valid ? head.code : 8'h00;
    assign ev_ext     = ev_valid && head.ext;
    assign ev_break   = ev_valid && head.brk;
    assign fifo_count = cnt_q;
    assign overflow   = ovf_q;
    assign last_make  = last_make_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Bench for ps2_key_event_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based event model.
module tb_ps2_key_event_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 40;
    localparam bit SUPP  = 1'b1;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    logic       clk_50mhz = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       ev_ready = 1'b0;
    logic       overflow_clr = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic [$clog2(DEPTH):0] fifo_count;
    logic       overflow;
    logic [7:0] last_make;

    ps2_key_event_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .SUPPRESS_REPEAT(SUPP)) dut (
        .clk_50mhz(clk_50mhz), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .ev_ready(ev_ready), .overflow_clr(overflow_clr), .ev_valid(ev_valid), .ev_code(ev_code),
        .ev_ext(ev_ext), .ev_break(ev_break), .fifo_count(fifo_count), .overflow(overflow),
        .last_make(last_make)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: pending-prefix flags, an event queue and the held key.
    ev_t        m_q[$];
    bit         m_pext, m_pbrk, m_hext, m_hvld, m_ovf;
    int         m_idle;
    logic [7:0] m_hcode, m_last;

    function automatic bit noise(input logic [7:0] b);
        return b == 8'h00 || b == 8'hFF || b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE;
    endfunction

    always @(posedge clk_50mhz) begin : model
        bit pe, pb, em, dp, ovf, dropped, hit;
        int idl;
        ev_t e;
        if (reset) begin
            m_q.delete();
            m_pext <= 0; m_pbrk <= 0; m_idle <= 0; m_ovf <= 0;
            m_hcode <= 8'h00; m_hext <= 0; m_hvld <= 0; m_last <= 8'h00;
        end else begin
            pe = m_pext; pb = m_pbrk; idl = m_idle; em = 0; e = '0;
            ovf = m_ovf; dropped = 0;
            dp = (m_q.size() != 0) && ev_ready;
            if (byte_valid) begin
                idl = 0;
                if (!pe && !pb) begin
                    if (byte_in == 8'hE0)      pe = 1;
                    else if (byte_in == 8'hF0) pb = 1;
                    else if (!noise(byte_in)) begin em = 1; e = '{byte_in, 1'b0, 1'b0}; end
                end else if (!pb) begin
                    if (byte_in == 8'hF0) pb = 1;
                    else if (byte_in != 8'hE0) begin em = 1; e = '{byte_in, 1'b1, 1'b0}; pe = 0; end
                end else if (byte_in != 8'hE0 && byte_in != 8'hF0) begin
                    em = 1; e = '{byte_in, pe, 1'b1}; pe = 0; pb = 0;
                end
            end else if (pe || pb) begin
                idl++;
                if (idl == TMO) begin pe = 0; pb = 0; idl = 0; end
            end else begin
                idl = 0;
            end
            if (dp) void'(m_q.pop_front());
            if (em) begin
                hit = m_hvld && m_hcode == e.code && m_hext == e.ext;
                if (e.brk || !(SUPP && hit)) begin
                    if (m_q.size() < DEPTH) m_q.push_back(e);
                    else begin ovf = 1; dropped = 1; end
                    if (!e.brk) begin
                        m_hcode <= e.code; m_hext <= e.ext; m_hvld <= 1; m_last <= e.code;
                    end else if (hit) begin
                        m_hvld <= 0;
                    end
                end
            end
            if (!dropped && overflow_clr) ovf = 0;
            m_pext <= pe; m_pbrk <= pb; m_idle <= idl; m_ovf <= ovf;
        end
    end

    // Accepted-event log for the directed scenarios.
    int  n_pop = 0;
    ev_t last_pop = '0;
    always @(posedge clk_50mhz) begin
        if (!reset && ev_valid && ev_ready) begin
            n_pop    <= n_pop + 1;
            last_pop <= '{ev_code, ev_ext, ev_break};
        end
    end

    always @(negedge clk_50mhz) begin : compare
        bit v;
        if (chk_en && !reset) begin
            v = (m_q.size() != 0);
            check("m_ev_valid", ev_valid, v);
            check("m_ev_code", ev_code, v ? m_q[0].code : 8'h00);
            check("m_ev_ext", ev_ext, v ? m_q[0].ext : 1'b0);
            check("m_ev_break", ev_break, v ? m_q[0].brk : 1'b0);
            check("m_fifo_count", fifo_count, m_q.size());
            check("m_overflow", overflow, m_ovf);
            check("m_last_make", last_make, m_last);
        end
    end

    task automatic send(input logic [7:0] b);
        byte_in = b; byte_valid = 1'b1;
        @(negedge clk_50mhz);
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50mhz);
    endtask

    task automatic do_reset();
        reset = 1'b1; byte_valid = 1'b0; overflow_clr = 1'b0;
        @(negedge clk_50mhz);
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, ev_valid, 0);
        check({tag, "_code"}, ev_code, 8'h00);
        check({tag, "_ext"}, ev_ext, 0);
        check({tag, "_brk"}, ev_break, 0);
        check({tag, "_count"}, fifo_count, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_last"}, last_make, 8'h00);
    endtask

    logic [7:0] pool [10];
    logic [7:0] fill [5];
    int base;

    initial begin
        pool = '{8'hE0, 8'hF0, 8'h1C, 8'h29, 8'h75, 8'h12, 8'h1C, 8'h00, 8'hAA, 8'hF0};
        fill = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        repeat (3) @(negedge clk_50mhz);
        reset  = 1'b0;
        chk_en = 1'b1;
        check_reset_state("rst0");

        // Single make, one-cycle latency.
        ev_ready = 1'b1;
        send(8'h1C);
        check("t1_valid", ev_valid, 1);
        check("t1_code", ev_code, 8'h1C);
        check("t1_ext_brk", {ev_ext, ev_break}, 2'b00);
        check("t1_last", last_make, 8'h1C);
        idle(2);

        // Extended break; prefixes emit nothing.
        base = n_pop;
        send(8'hE0); check("t2_e0", ev_valid, 0);
        send(8'hF0); check("t2_f0", ev_valid, 0);
        send(8'h75);
        check("t2_ev", {ev_code, ev_ext, ev_break}, {8'h75, 2'b11});
        idle(2);
        check("t2_npop", n_pop - base, 1);

        // Typematic repeats collapse to one make, then the break.
        do_reset();
        ev_ready = 1'b1;
        base = n_pop;
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        idle(3);
        check("t3_npop", n_pop - base, 2);
        check("t3_last_pop", last_pop, {8'h1C, 2'b01});

        // Timeout boundary: one cycle short keeps the prefix, full timeout drops it.
        send(8'hE0); idle(TMO - 1); send(8'h29);
        check("t4_keep", {ev_code, ev_ext, ev_break}, {8'h29, 2'b10});
        idle(2);
        send(8'hE0); idle(TMO); send(8'h29);
        check("t4_abort", {ev_code, ev_ext, ev_break}, {8'h29, 2'b00});
        idle(2);

        // Fill past DEPTH with the consumer stalled.
        do_reset();
        ev_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(fill[i]);
        check("t5_count", fifo_count, 4);
        check("t5_ovf", overflow, 1);
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5_pop_code", ev_code, fill[i]);
            @(negedge clk_50mhz);
        end
        check("t5_empty", ev_valid, 0);
        overflow_clr = 1'b1;
        @(negedge clk_50mhz);
        overflow_clr = 1'b0;
        check("t5_ovf_clr", overflow, 0);

        // Reset discards a pending break prefix.
        send(8'hF0);
        do_reset();
        check_reset_state("rst6");
        send(8'h1C);
        check("t6_ev", {ev_code, ev_ext, ev_break}, {8'h1C, 2'b00});
        idle(2);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            reset        = ($urandom_range(0, 399) == 0);
            byte_valid   = ($urandom_range(0, 9) < 4);
            byte_in      = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
            ev_ready     = ((c / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            overflow_clr = ($urandom_range(0, 24) == 0);
            @(negedge clk_50mhz);
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b0; byte_valid = 1'b0;
                idle(TMO + 5);
            end
        end
        reset = 1'b0; byte_valid = 1'b0; overflow_clr = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
